// File: rtl/proc_controller_if.sv
// Control bundle between the instruction sequencer and the shared-bus datapath.
interface proc_controller_if;
  logic       run;
  logic [8:0] ir;
  logic       g_nz;
  logic [3:0] bus_sel;
  logic [7:0] r_in;
  logic       a_in;
  logic       g_in;
  logic       ir_in;
  logic       addr_in;
  logic       dout_in;
  logic       w_d;
  logic       pc_incr;
  logic       addsub;
  logic       done;

  modport master (
    input  run, ir, g_nz,
    output bus_sel, r_in, a_in, g_in, ir_in, addr_in, dout_in, w_d, pc_incr, addsub, done
  );

  modport slave (
    output run, ir, g_nz,
    input  bus_sel, r_in, a_in, g_in, ir_in, addr_in, dout_in, w_d, pc_incr, addsub, done
  );
endinterface

// File: rtl/proc_controller.sv
// Instruction sequencer for the shared-bus processor: fetch, decode, per-step bus/load control.
// Optional feature macro: CTRL_MVNZ_EN (opcode 110 = mvnz; otherwise nop).
module proc_controller #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  proc_controller_if.master     ctl
);
  localparam logic [2:0] FETCH0 = 3'd0;
  localparam logic [2:0] FWAIT  = 3'd1;
  localparam logic [2:0] FETCH2 = 3'd2;
  localparam logic [2:0] EXEC0  = 3'd3;
  localparam logic [2:0] EXEC1  = 3'd4;
  localparam logic [2:0] EWAIT  = 3'd5;
  localparam logic [2:0] EXEC2  = 3'd6;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;

  localparam logic [1:0] WAIT_LD  = 2'(MEM_WAIT);
  localparam bit         HAS_WAIT = (MEM_WAIT != 0);

  logic [2:0] state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [2:0] op, rx, ry;
  logic [7:0] rx_oh;

  assign op    = ctl.ir[8:6];
  assign rx    = ctl.ir[5:3];
  assign ry    = ctl.ir[2:0];
  assign rx_oh = 8'd1 << rx;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= FETCH0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      FETCH0: if (ctl.run) begin
        if (HAS_WAIT) begin
          state_n = FWAIT;
          cnt_n   = WAIT_LD;
        end else begin
          state_n = FETCH2;
        end
      end
      FWAIT: begin
        if (cnt == 2'd1) state_n = FETCH2;
        else             cnt_n   = cnt - 2'd1;
      end
      FETCH2: state_n = EXEC0;
      EXEC0: begin
        case (op)
          OP_MVI, OP_LD: begin
            if (HAS_WAIT) begin
              state_n = EWAIT;
              cnt_n   = WAIT_LD;
            end else begin
              state_n = EXEC2;
            end
          end
          OP_ADD, OP_SUB, OP_ST: state_n = EXEC1;
          default:               state_n = FETCH0;
        endcase
      end
      EXEC1: state_n = (op == OP_ST) ? FETCH0 : EXEC2;
      EWAIT: begin
        if (cnt == 2'd1) state_n = EXEC2;
        else             cnt_n   = cnt - 2'd1;
      end
      EXEC2:   state_n = FETCH0;
      default: state_n = FETCH0;
    endcase
  end

`ifndef CTRL_MVNZ_EN
  logic unused_g_nz;
  assign unused_g_nz = ctl.g_nz;
`endif

  // Outputs are forced idle while resetn is low, even though FETCH0 with run=1 would fetch.
  always_comb begin
    ctl.bus_sel = 4'hF;
    ctl.r_in    = '0;
    ctl.a_in    = 1'b0;
    ctl.g_in    = 1'b0;
    ctl.ir_in   = 1'b0;
    ctl.addr_in = 1'b0;
    ctl.dout_in = 1'b0;
    ctl.w_d     = 1'b0;
    ctl.pc_incr = 1'b0;
    ctl.addsub  = 1'b0;
    ctl.done    = 1'b0;
    if (resetn) begin
      case (state)
        FETCH0: if (ctl.run) begin
          ctl.bus_sel = 4'd12;
          ctl.addr_in = 1'b1;
          ctl.pc_incr = 1'b1;
        end
        FETCH2: begin
          ctl.bus_sel = 4'd10;
          ctl.ir_in   = 1'b1;
        end
        EXEC0: begin
          case (op)
            OP_MV: begin
              ctl.bus_sel = {1'b0, ry};
              ctl.r_in    = rx_oh;
              ctl.done    = 1'b1;
            end
            OP_MVI: begin
              ctl.bus_sel = 4'd12;
              ctl.addr_in = 1'b1;
              ctl.pc_incr = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctl.bus_sel = {1'b0, rx};
              ctl.a_in    = 1'b1;
            end
            OP_LD, OP_ST: begin
              ctl.bus_sel = {1'b0, ry};
              ctl.addr_in = 1'b1;
            end
`ifdef CTRL_MVNZ_EN
            OP_MVNZ: begin
              ctl.bus_sel = {1'b0, ry};
              ctl.r_in    = ctl.g_nz ? rx_oh : '0;
              ctl.done    = 1'b1;
            end
`endif
            default: ctl.done = 1'b1;
          endcase
        end
        EXEC1: begin
          if (op == OP_ST) begin
            ctl.bus_sel = {1'b0, rx};
            ctl.dout_in = 1'b1;
            ctl.w_d     = 1'b1;
            ctl.done    = 1'b1;
          end else begin
            ctl.bus_sel = {1'b0, ry};
            ctl.g_in    = 1'b1;
            ctl.addsub  = (op == OP_SUB);
          end
        end
        EXEC2: begin
          ctl.done = 1'b1;
          if (op == OP_ADD || op == OP_SUB) begin
            ctl.bus_sel = 4'd8;
          end else begin
            ctl.bus_sel = 4'd10;
          end
          ctl.r_in = rx_oh;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_proc_controller.sv
// Directed bench for proc_controller: two instances (MEM_WAIT=1 and 3) checked cycle by cycle from a queue.
module tb_proc_controller;
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  proc_controller_if if1 ();
  proc_controller_if if3 ();

  proc_controller #(.MEM_WAIT(1)) u1 (.clock(clock), .resetn(resetn), .ctl(if1));
  proc_controller #(.MEM_WAIT(3)) u3 (.clock(clock), .resetn(resetn), .ctl(if3));

  localparam logic [8:0] F_A    = 9'b1_0000_0000;
  localparam logic [8:0] F_G    = 9'b0_1000_0000;
  localparam logic [8:0] F_IR   = 9'b0_0100_0000;
  localparam logic [8:0] F_ADDR = 9'b0_0010_0000;
  localparam logic [8:0] F_DOUT = 9'b0_0001_0000;
  localparam logic [8:0] F_WD   = 9'b0_0000_1000;
  localparam logic [8:0] F_PC   = 9'b0_0000_0100;
  localparam logic [8:0] F_SUB  = 9'b0_0000_0010;
  localparam logic [8:0] F_DONE = 9'b0_0000_0001;
  localparam logic [20:0] IDLE  = {4'hF, 8'h00, 9'b0};

  logic [20:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [20:0] v(input logic [3:0] bs, input logic [7:0] ri, input logic [8:0] fl);
    return {bs, ri, fl};
  endfunction

  function automatic logic [20:0] snap(input int sel);
    if (sel != 0)
      return {if3.bus_sel, if3.r_in, if3.a_in, if3.g_in, if3.ir_in, if3.addr_in,
              if3.dout_in, if3.w_d, if3.pc_incr, if3.addsub, if3.done};
    return {if1.bus_sel, if1.r_in, if1.a_in, if1.g_in, if1.ir_in, if1.addr_in,
            if1.dout_in, if1.w_d, if1.pc_incr, if1.addsub, if1.done};
  endfunction

  task automatic chk(input int sel, input string tag);
    logic [20:0] obs;
    logic [20:0] exp;
    obs = snap(sel);
    exp = '1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic setrun(input int sel, input logic r);
    if (sel != 0) if3.run = r;
    else          if1.run = r;
  endtask

  task automatic setir(input int sel, input logic [8:0] instr, input logic gnz);
    if (sel != 0) begin if3.ir = instr; if3.g_nz = gnz; end
    else          begin if1.ir = instr; if1.g_nz = gnz; end
  endtask

  // Expected per-cycle outputs come from the instruction step table, then the DUT is stepped.
  task automatic run_instr(input int sel, input logic [8:0] instr, input logic gnz,
                           input bit b2b, input string tag);
    int unsigned w;
    logic [2:0] op;
    logic [3:0] rx, ry;
    logic [7:0] oh;
    w  = (sel != 0) ? 3 : 1;
    op = instr[8:6];
    rx = {1'b0, instr[5:3]};
    ry = {1'b0, instr[2:0]};
    oh = 8'd1 << instr[5:3];
    exp_q.push_back(v(4'd12, 8'h00, F_ADDR | F_PC));
    for (int unsigned i = 0; i < w; i++) exp_q.push_back(IDLE);
    exp_q.push_back(v(4'd10, 8'h00, F_IR));
    case (op)
      3'b000: exp_q.push_back(v(ry, oh, F_DONE));
      3'b001: begin
        exp_q.push_back(v(4'd12, 8'h00, F_ADDR | F_PC));
        for (int unsigned i = 0; i < w; i++) exp_q.push_back(IDLE);
        exp_q.push_back(v(4'd10, oh, F_DONE));
      end
      3'b010, 3'b011: begin
        exp_q.push_back(v(rx, 8'h00, F_A));
        exp_q.push_back(v(ry, 8'h00, (op == 3'b011) ? (F_G | F_SUB) : F_G));
        exp_q.push_back(v(4'd8, oh, F_DONE));
      end
      3'b100: begin
        exp_q.push_back(v(ry, 8'h00, F_ADDR));
        for (int unsigned i = 0; i < w; i++) exp_q.push_back(IDLE);
        exp_q.push_back(v(4'd10, oh, F_DONE));
      end
      3'b101: begin
        exp_q.push_back(v(ry, 8'h00, F_ADDR));
        exp_q.push_back(v(rx, 8'h00, F_DOUT | F_WD | F_DONE));
      end
`ifdef CTRL_MVNZ_EN
      3'b110: exp_q.push_back(v(ry, gnz ? oh : 8'h00, F_DONE));
`else
      3'b110: exp_q.push_back(IDLE | 21'(F_DONE));
`endif
      default: exp_q.push_back(IDLE | 21'(F_DONE));
    endcase
    exp_q.push_back(b2b ? v(4'd12, 8'h00, F_ADDR | F_PC) : IDLE);

    setir(sel, instr, gnz);
    setrun(sel, 1'b1);
    #1 chk(sel, tag);
    while (exp_q.size() != 0) begin
      @(negedge clock);
      chk(sel, tag);
      if (!b2b) setrun(sel, 1'b0);
    end
    setrun(sel, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    if1.run = 1'b1; if1.ir = '0; if1.g_nz = 1'b0;
    if3.run = 1'b1; if3.ir = '0; if3.g_nz = 1'b0;
    #2;
    exp_q.push_back(IDLE); chk(0, "rst_run1_u1");
    exp_q.push_back(IDLE); chk(1, "rst_run1_u3");
    @(negedge clock);
    @(negedge clock);
    if1.run = 1'b0;
    if3.run = 1'b0;
    resetn = 1'b1;
    repeat (10) begin
      @(negedge clock);
      exp_q.push_back(IDLE); chk(0, "idle_u1");
      exp_q.push_back(IDLE); chk(1, "idle_u3");
    end

    run_instr(0, 9'b000_010_101, 1'b0, 1'b0, "mv_r2_r5");
    run_instr(0, 9'b011_001_011, 1'b0, 1'b1, "sub_r1_r3_b2b");
    run_instr(0, 9'b010_111_110, 1'b0, 1'b0, "add_r7_r6");
    run_instr(0, 9'b101_100_000, 1'b0, 1'b0, "st_r4_r0");
    run_instr(0, 9'b100_011_110, 1'b0, 1'b0, "ld_w1");
    run_instr(1, 9'b100_110_010, 1'b0, 1'b0, "ld_w3");
    run_instr(1, 9'b001_000_111, 1'b0, 1'b0, "mvi_w3");
    run_instr(0, 9'b111_101_010, 1'b0, 1'b0, "nop");
    run_instr(0, 9'b110_000_001, 1'b0, 1'b0, "mvnz_gnz0");
    run_instr(0, 9'b110_000_001, 1'b1, 1'b0, "mvnz_gnz1");

    // Reset pulse during the mvi memory wait: the pending E2 write must never appear.
    if1.ir = 9'b001_011_000;
    if1.run = 1'b1;
    exp_q.push_back(v(4'd12, 8'h00, F_ADDR | F_PC));
    #1 chk(0, "rstmvi_f0");
    @(negedge clock);
    if1.run = 1'b0;
    exp_q.push_back(IDLE); chk(0, "rstmvi_fwait");
    @(negedge clock);
    exp_q.push_back(v(4'd10, 8'h00, F_IR)); chk(0, "rstmvi_f2");
    @(negedge clock);
    exp_q.push_back(v(4'd12, 8'h00, F_ADDR | F_PC)); chk(0, "rstmvi_e0");
    @(negedge clock);
    exp_q.push_back(IDLE); chk(0, "rstmvi_ewait");
    resetn = 1'b0;
    #1;
    exp_q.push_back(IDLE); chk(0, "rstmvi_in_rst");
    @(negedge clock);
    exp_q.push_back(IDLE); chk(0, "rstmvi_no_e2");
    resetn = 1'b1;
    repeat (2) begin
      @(negedge clock);
      exp_q.push_back(IDLE); chk(0, "rstmvi_after");
      exp_q.push_back(IDLE); chk(1, "rstmvi_u3");
    end

    run_instr(0, 9'b000_110_100, 1'b0, 1'b0, "mv_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
